audio_frame_scheduler: RTL and testbench

Sequencer that walks a sample RAM of 32-bit IEEE-754 single-precision audio samples frame by frame. It computes a min/max pair for each frame and hands each result out on a valid/ready handshake. It replaces the single-shot min/max engine's whole-array port with an addressed memory read stream. It sits between the sample buffer (written by the wav-to-raw loader) and downstream statistics/normalisation logic.

---
 rtl/audio_frame_scheduler_pkg.sv | 25 ++
 rtl/audio_frame_scheduler_minmax_acc.sv | 41 ++++
 rtl/audio_frame_scheduler.sv | 142 ++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_frame_scheduler_pkg.sv
// Shared fp32 constants, scheduler state encoding and the total-order key
// used to compare raw IEEE-754 single-precision bit patterns.
package audio_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_FLUSH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Maps an fp32 pattern to an unsigned key whose order matches numeric
  // order, with -0 below +0; NaNs simply fall wherever their bits put them.
  function automatic logic [FP32_W-1:0] fp32_key(input logic [FP32_W-1:0] s);
    if (s[FP32_W-1] == 1'b0) begin
      fp32_key = {1'b1, s[FP32_W-2:0]};
    end else begin
      fp32_key = ~s;
    end
  endfunction

endpackage

// File: rtl/audio_frame_scheduler_minmax_acc.sv
// Registered min/max accumulator over a stream of fp32 samples; load seeds
// both extremes, upd folds in a further sample, ties keep the held value.
module fp32_minmax_acc
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              upd,
  input  logic [FP32_W-1:0] sample,
  output logic [FP32_W-1:0] cur_min,
  output logic [FP32_W-1:0] cur_max
);

  logic [FP32_W-1:0] min_reg;
  logic [FP32_W-1:0] max_reg;
  logic [FP32_W-1:0] sample_key;

  assign sample_key = fp32_key(sample);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (load) begin
      min_reg <= sample;
      max_reg <= sample;
    end else if (upd) begin
      if (sample_key < fp32_key(min_reg)) begin
        min_reg <= sample;
      end
      if (sample_key > fp32_key(max_reg)) begin
        max_reg <= sample;
      end
    end
  end

  assign cur_min = min_reg;
  assign cur_max = max_reg;

endmodule

// File: rtl/audio_frame_scheduler.sv
// Walks the sample RAM frame by frame, reduces each frame to a min/max pair
// and presents every result on a valid/ready handshake.
module audio_frame_scheduler
  import audio_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 100,
  parameter int NFR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NFR_W-1:0]  num_frames,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [NFR_W-1:0]  res_frame,
  output logic              d
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [NFR_W:0]   FRAME_ONE = (NFR_W + 1)'(1);

  state_t             state_reg;
  logic [NFR_W-1:0]   num_frames_reg;
  logic [NFR_W-1:0]   frame_idx_reg;
  logic [CNT_W-1:0]   rd_cnt_reg;
  logic               mem_rd_en_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic               res_valid_reg;
  logic               d_reg;
  logic               cap_vld_reg;
  logic               cap_first_reg;
  logic               more_frames;
  logic [FP32_W-1:0]  acc_min;
  logic [FP32_W-1:0]  acc_max;

  assign more_frames = ({1'b0, frame_idx_reg} + FRAME_ONE) < {1'b0, num_frames_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      num_frames_reg <= '0;
      frame_idx_reg  <= '0;
      rd_cnt_reg     <= '0;
      mem_rd_en_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      res_valid_reg  <= 1'b0;
      d_reg          <= 1'b0;
      cap_vld_reg    <= 1'b0;
      cap_first_reg  <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe, so the capture
      // controls are the strobe delayed by one cycle.
      cap_vld_reg   <= mem_rd_en_reg;
      cap_first_reg <= mem_rd_en_reg && (rd_cnt_reg == '0);
      d_reg         <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            num_frames_reg <= num_frames;
            frame_idx_reg  <= '0;
            mem_addr_reg   <= base_addr;
            rd_cnt_reg     <= '0;
            if (num_frames == '0) begin
              state_reg <= ST_DONE;
              d_reg     <= 1'b1;
            end else begin
              state_reg     <= ST_FETCH;
              mem_rd_en_reg <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          // The pointer also steps past the last read, so the next frame
          // starts where this one ended; wrap is the natural overflow.
          mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
          if (rd_cnt_reg == LAST_IDX) begin
            rd_cnt_reg    <= '0;
            mem_rd_en_reg <= 1'b0;
            state_reg     <= ST_FLUSH;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          state_reg     <= ST_HOLD;
          res_valid_reg <= 1'b1;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            if (more_frames) begin
              frame_idx_reg <= frame_idx_reg + NFR_W'(1);
              mem_rd_en_reg <= 1'b1;
              state_reg     <= ST_FETCH;
            end else begin
              state_reg <= ST_DONE;
              d_reg     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // The accumulator registers double as the result registers: they only
  // change once the next frame's first sample lands, after the handshake.
  fp32_minmax_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .load    (cap_vld_reg & cap_first_reg),
    .upd     (cap_vld_reg & ~cap_first_reg),
    .sample  (mem_rd_data[FP32_W-1:0]),
    .cur_min (acc_min),
    .cur_max (acc_max)
  );

  assign busy      = (state_reg != ST_IDLE);
  assign mem_rd_en = mem_rd_en_reg;
  assign mem_addr  = mem_addr_reg;
  assign res_valid = res_valid_reg;
  assign res_min   = DATA_W'(acc_min);
  assign res_max   = DATA_W'(acc_max);
  assign res_frame = frame_idx_reg;
  assign d         = d_reg;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler with a frame length of 4: address
// and result scoreboards are filled when a job starts and drained by a monitor.
module tb_audio_frame_scheduler;

  localparam int L = 4;

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    logic [7:0]  fr;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [7:0]  num_frames;
  logic        busy;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_min;
  logic [31:0] res_max;
  logic [7:0]  res_frame;
  logic        d;

  logic [31:0] ram [0:1023];
  logic [9:0]  exp_addr [$];
  res_t        exp_res [$];
  int          checks = 0;
  int          errors = 0;
  int          d_cnt  = 0;

  audio_frame_scheduler #(
    .ADDR_W(10), .DATA_W(32), .FRAME_LEN(L), .NFR_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_frames  (num_frames),
    .busy        (busy),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_min     (res_min),
    .res_max     (res_max),
    .res_frame   (res_frame),
    .d           (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: one line per read and per accepted result.
  always @(negedge clk) begin
    if (d) d_cnt++;
    if (reset && mem_rd_en) begin
      if (exp_addr.size() == 0) begin
        check32("addr_unexpected", {22'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] ea;
        ea = exp_addr.pop_front();
        $display("read  addr=%h expected=%h", mem_addr, ea);
        check32("mem_addr", {22'd0, mem_addr}, {22'd0, ea});
      end
    end
    if (reset && res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        check32("res_unexpected", res_min, 32'hFFFF_FFFF);
      end else begin
        res_t er;
        er = exp_res.pop_front();
        $display("result frame=%0d min=%h max=%h", res_frame, res_min, res_max);
        check32("res_min", res_min, er.mn);
        check32("res_max", res_max, er.mx);
        check32("res_frame", {24'd0, res_frame}, {24'd0, er.fr});
      end
    end
  end

  task automatic push_reads(input logic [9:0] base, input int n);
    for (int i = 0; i < n * L; i++) exp_addr.push_back(10'(base + 10'(i)));
  endtask

  task automatic push_res(input logic [31:0] mn, input logic [31:0] mx, input logic [7:0] fr);
    res_t r;
    r.mn = mn; r.mx = mx; r.fr = fr;
    exp_res.push_back(r);
  endtask

  // Drives a one-cycle start; returns just after the sampling edge E0.
  task automatic do_start(input logic [9:0] b, input logic [7:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_frames = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_d(input int budget, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d) begin found = 1; break; end
    end
    check32(tag, found, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_before;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[0] = 32'h3F80_0000; ram[1] = 32'hC000_0000; ram[2] = 32'h4040_0000; ram[3] = 32'h0000_0000;
    ram[4] = 32'h8000_0000; ram[5] = 32'h0000_0000; ram[6] = 32'h8000_0000; ram[7] = 32'h0000_0000;
    ram[8] = 32'hBF80_0000; ram[9] = 32'h7F80_0000; ram[10] = 32'hFF80_0000; ram[11] = 32'h4000_0000;
    ram[16] = 32'h3F80_0000; ram[17] = 32'h3F80_0000; ram[18] = 32'h4000_0000; ram[19] = 32'hBF80_0000;
    ram[24] = 32'h7FC0_0000; ram[25] = 32'h0000_0001; ram[26] = 32'h8000_0001; ram[27] = 32'h3F80_0000;
    ram[1022] = 32'h4200_0000; ram[1023] = 32'h3F00_0000;

    reset = 1'b0; start = 1'b0; base_addr = '0; num_frames = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check32("rst_busy", {31'd0, busy}, 0);
    check32("rst_rd_en", {31'd0, mem_rd_en}, 0);
    check32("rst_valid", {31'd0, res_valid}, 0);
    check32("rst_d", {31'd0, d}, 0);
    check32("rst_addr", {22'd0, mem_addr}, 0);
    check32("rst_min", res_min, 0);
    check32("rst_max", res_max, 0);
    check32("rst_frame", {24'd0, res_frame}, 0);
    reset = 1'b1;

    // Single frame with exact latency and done timing.
    push_reads(10'h000, 1);
    push_res(32'hC000_0000, 32'h4040_0000, 8'd0);
    do_start(10'h000, 8'd1);
    repeat (L) @(posedge clk);
    @(negedge clk) check32("t1_valid_early", {31'd0, res_valid}, 0);
    @(negedge clk) check32("t1_valid_rise", {31'd0, res_valid}, 1);
    @(negedge clk) check32("t1_d_pulse", {31'd0, d}, 1);
    check32("t1_busy_in_done", {31'd0, busy}, 1);
    @(negedge clk) check32("t1_d_low", {31'd0, d}, 0);
    check32("t1_busy_low", {31'd0, busy}, 0);

    // Two frames back to back; second frame orders -0 below +0.
    push_reads(10'h000, 2);
    push_res(32'hC000_0000, 32'h4040_0000, 8'd0);
    push_res(32'h8000_0000, 32'h0000_0000, 8'd1);
    do_start(10'h000, 8'd2);
    repeat (L + 1) @(posedge clk);
    @(negedge clk) check32("t2_valid_f0", {31'd0, res_valid}, 1);
    repeat (L + 1) @(posedge clk);
    @(negedge clk) check32("t2_valid_gap", {31'd0, res_valid}, 0);
    @(negedge clk) check32("t2_valid_f1", {31'd0, res_valid}, 1);
    wait_d(4, "t2_done");

    // Backpressure in HOLD; infinities order correctly.
    res_ready = 1'b0;
    push_reads(10'h008, 1);
    push_res(32'hFF80_0000, 32'h7F80_0000, 8'd0);
    do_start(10'h008, 8'd1);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (res_valid) begin found = 1; break; end
      end
      check32("t3_valid_seen", found, 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32("t3_hold_valid", {31'd0, res_valid}, 1);
      check32("t3_hold_rd_en", {31'd0, mem_rd_en}, 0);
      check32("t3_hold_min", res_min, 32'hFF80_0000);
      check32("t3_hold_max", res_max, 32'h7F80_0000);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 check32("t3_valid_drop", {31'd0, res_valid}, 0);
    check32("t3_d_after_hs", {31'd0, d}, 1);
    @(negedge clk);

    // Address wrap at the top of the RAM.
    push_reads(10'h3FE, 1);
    push_res(32'hC000_0000, 32'h4200_0000, 8'd0);
    do_start(10'h3FE, 8'd1);
    wait_d(20, "t4_done");

    // Zero frames: no reads, immediate done.
    do_start(10'h000, 8'd0);
    wait_d(3, "t5_nf0_done");
    @(negedge clk) check32("t5_nf0_idle", {31'd0, busy}, 0);

    // Start while busy must be ignored.
    push_reads(10'h010, 1);
    push_res(32'hBF80_0000, 32'h4000_0000, 8'd0);
    do_start(10'h010, 8'd1);
    do_start(10'h064, 8'd5);
    wait_d(20, "t5_busy_start_done");

    // Reset mid-FETCH aborts the job.
    push_reads(10'h014, 1);
    do_start(10'h014, 8'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check32("t6_rd_en_rst", {31'd0, mem_rd_en}, 0);
    check32("t6_busy_rst", {31'd0, busy}, 0);
    check32("t6_valid_rst", {31'd0, res_valid}, 0);
    exp_addr.delete();
    d_before = d_cnt;
    @(negedge clk) reset = 1'b1;
    repeat (6) @(negedge clk);
    check32("t6_no_d", d_cnt, d_before);
    check32("t6_no_valid", {31'd0, res_valid}, 0);

    // Clean frame after reset; NaN sorts by bit pattern.
    push_reads(10'h018, 1);
    push_res(32'h8000_0001, 32'h7FC0_0000, 8'd0);
    do_start(10'h018, 8'd1);
    wait_d(20, "t6_clean_done");

    repeat (3) @(negedge clk);
    check32("end_addr_q_empty", exp_addr.size(), 0);
    check32("end_res_q_empty", exp_res.size(), 0);
    check32("end_d_count", d_cnt, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
